// File: rtl/wavegen_instr_sequencer.sv
// rtl/wavegen_instr_sequencer.sv - program sequencer dispatching wave instructions to the DataMover executor
//
// Purpose: holds a small program of 128-bit wave instructions in on-chip RAM.
//   On start it walks the program counter, issues PLAY instructions one at a
//   time to the executor, and waits for each one to finish before fetching the
//   next. Supports counted JUMP loops, END, host stop and illegal-opcode errors.
//
// Optional build macro: SEQ_WATCHDOG_EN adds parameter WDOG_CYC and a 24-bit
//   watchdog that aborts with error if the executor never finishes.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   prog_we        program RAM write strobe (honoured only while idle)
//   prog_addr      program write address
//   prog_wdata     program write data
//   start          start pulse, runs from address 0 (honoured only while idle)
//   stop           stop request, latched while running
//   instr_out      instruction presented to the executor
//   instr_valid    one-cycle dispatch strobe
//   exec_done      executor idle / finished (high when idle)
//   busy           sequencer not idle
//   pc             current program counter
//   seq_done       one-cycle pulse on completion, stop or error
//   error          sticky illegal-opcode / watchdog flag, cleared by start

module wavegen_instr_sequencer #(
    parameter int ADDR_W    = 6,
    parameter int GUARD_CYC = 2
`ifdef SEQ_WATCHDOG_EN
    ,
    parameter int WDOG_CYC  = 2**20
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [127:0]      prog_wdata,
    input  logic              start,
    input  logic              stop,
    output logic [127:0]      instr_out,
    output logic              instr_valid,
    input  logic              exec_done,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic              seq_done,
    output logic              error
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_LAST   = '1;
    localparam logic [7:0]        GUARD_LIM = 8'(GUARD_CYC);

    localparam logic [3:0] OP_PLAY = 4'h1;
    localparam logic [3:0] OP_JUMP = 4'h2;
    localparam logic [3:0] OP_END  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [127:0]      instr_q;
    logic              instr_valid_q;
    logic              seq_done_q;
    logic              error_q;
    logic              stop_q;
    logic              loop_act_q;
    logic [15:0]       loop_q;
    logic [7:0]        guard_q;

    logic [127:0]      mem [DEPTH];

    // Decoded fields of the instruction currently held in instr_out.
    logic [3:0]        opcode;
    logic [15:0]       seg_times;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [15:0]       jmp_cnt;

    assign opcode    = instr_q[3:0];
    assign seg_times = instr_q[19:4];
    assign jmp_tgt   = instr_q[104 +: ADDR_W];
    assign jmp_cnt   = instr_q[127:112];

    // RAM: no reset on contents; writes only while idle.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE)) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // JUMP falls through (pc+1) when no loop is armed and C == 0, or when
    // the armed loop has run out of iterations.
    logic jump_fall_d;
    logic guard_done_d;
    logic advance_d;
    logic wdog_hit_d;

    assign jump_fall_d  = loop_act_q ? (loop_q == 16'd0) : (jmp_cnt == 16'd0);
    assign guard_done_d = (guard_q == GUARD_LIM);

    // All pc+1 paths funnel through advance_d so the end-of-RAM rule
    // (no wrap, treated as END) lives in one place.
    always_comb begin
        advance_d = 1'b0;
        case (state_q)
            S_DECODE:    advance_d = !stop_q &&
                                     (((opcode == OP_PLAY) && (seg_times == 16'd0)) ||
                                      ((opcode == OP_JUMP) && jump_fall_d));
            S_WAIT_BUSY: advance_d = guard_done_d && exec_done;
            S_WAIT_DONE: advance_d = exec_done;
            default:     advance_d = 1'b0;
        endcase
    end

`ifdef SEQ_WATCHDOG_EN
    localparam logic [23:0] WDOG_LIM = 24'(WDOG_CYC);
    logic [23:0] wdog_q;

    assign wdog_hit_d = ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE)) &&
                        (wdog_q == WDOG_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= 24'd0;
        end else if (state_q == S_ISSUE) begin
            wdog_q <= 24'd0;
        end else if ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE)) begin
            wdog_q <= wdog_q + 24'd1;
        end
    end
`else
    assign wdog_hit_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            seq_done_q    <= 1'b0;
            error_q       <= 1'b0;
            stop_q        <= 1'b0;
            loop_act_q    <= 1'b0;
            loop_q        <= 16'd0;
            guard_q       <= 8'd0;
        end else begin
            instr_valid_q <= 1'b0;
            seq_done_q    <= 1'b0;

            if ((state_q != S_IDLE) && stop) begin
                stop_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    // start wins over a simultaneous stop: the latch is cleared.
                    if (start) begin
                        pc_q       <= '0;
                        error_q    <= 1'b0;
                        loop_act_q <= 1'b0;
                        stop_q     <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    instr_q <= mem[pc_q];
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (stop_q) begin
                        seq_done_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        case (opcode)
                            OP_PLAY: begin
                                if (seg_times != 16'd0) begin
                                    instr_valid_q <= 1'b1;
                                    state_q       <= S_ISSUE;
                                end
                            end
                            OP_JUMP: begin
                                state_q <= S_FETCH;
                                if (!loop_act_q) begin
                                    if (jmp_cnt != 16'd0) begin
                                        loop_act_q <= 1'b1;
                                        loop_q     <= jmp_cnt - 16'd1;
                                        pc_q       <= jmp_tgt;
                                    end
                                end else if (loop_q == 16'd0) begin
                                    loop_act_q <= 1'b0;
                                end else begin
                                    loop_q <= loop_q - 16'd1;
                                    pc_q   <= jmp_tgt;
                                end
                            end
                            OP_END: begin
                                seq_done_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end
                            default: begin
                                error_q    <= 1'b1;
                                seq_done_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    guard_q <= 8'd0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // exec_done may still show the previous idle level right
                    // after dispatch, so it is not trusted until the guard expires.
                    if (!guard_done_d) begin
                        guard_q <= guard_q + 8'd1;
                    end else if (!exec_done) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (wdog_hit_d) begin
                error_q    <= 1'b1;
                seq_done_q <= 1'b1;
                state_q    <= S_IDLE;
            end else if (advance_d) begin
                if (pc_q == PC_LAST) begin
                    seq_done_q <= 1'b1;
                    state_q    <= S_IDLE;
                end else begin
                    pc_q    <= pc_q + 1'b1;
                    state_q <= S_FETCH;
                end
            end
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = instr_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign pc          = pc_q;
    assign seq_done    = seq_done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_wavegen_instr_sequencer.sv
// tb/tb_wavegen_instr_sequencer.sv - self-checking bench for wavegen_instr_sequencer

module tb_wavegen_instr_sequencer;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [127:0]      prog_wdata;
    logic              start;
    logic              stop;
    logic [127:0]      instr_out;
    logic              instr_valid;
    logic              exec_done;
    logic              busy;
    logic [ADDR_W-1:0] pc;
    logic              seq_done;
    logic              error;

    always #5 clk = ~clk;

    wavegen_instr_sequencer #(
        .ADDR_W    (ADDR_W),
        .GUARD_CYC (2)
`ifdef SEQ_WATCHDOG_EN
        ,
        .WDOG_CYC  (100)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .start       (start),
        .stop        (stop),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .busy        (busy),
        .pc          (pc),
        .seq_done    (seq_done),
        .error       (error)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int disp_cnt = 0;
    int first_cyc = -1;
    int exec_len = 16;
    bit exec_hold = 1'b0;
    int exec_cnt = 0;
    logic [127:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Executor model: drops done for exec_len beats after each dispatch.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_done <= 1'b1;
            exec_cnt  <= 0;
        end else if (instr_valid) begin
            if (exec_hold) begin
                exec_done <= 1'b0;
            end else if (exec_len > 0) begin
                exec_done <= 1'b0;
                exec_cnt  <= exec_len;
            end
        end else if (exec_cnt > 0) begin
            exec_cnt <= exec_cnt - 1;
            if (exec_cnt == 1) exec_done <= 1'b1;
        end
    end

    // Scoreboard: every dispatch pops the next expected instruction word.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            disp_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dispatch: unexpected instr_out %0h, no dispatch expected", instr_out);
            end else begin
                chk("dispatch_word", instr_out, exp_q.pop_front());
            end
        end
    end

    function automatic logic [127:0] mk(input logic [3:0] op, input logic [15:0] seg,
                                        input logic [32:0] addr, input logic [25:0] len,
                                        input logic [7:0] tgt, input logic [15:0] cnt);
        logic [127:0] w;
        w          = '0;
        w[3:0]     = op;
        w[19:4]    = seg;
        w[57:32]   = len;
        w[96:64]   = addr;
        w[111:104] = tgt;
        w[127:112] = cnt;
        return w;
    endfunction

    typedef struct {
        string               name;
        logic [5:0][127:0]   prog;
        int                  nw;
        int                  exec_len;
        int                  stop_after;
        bit                  sws;
        bit                  busy_wr;
        int                  nd;
        logic [7:0][5:0]     disp;
        logic [ADDR_W-1:0]   exp_pc;
        logic                exp_err;
    } tcase_t;

    function automatic tcase_t blank(input string n, input int el);
        tcase_t t;
        t.name       = n;
        t.prog       = '0;
        t.nw         = 0;
        t.exec_len   = el;
        t.stop_after = -1;
        t.sws        = 1'b0;
        t.busy_wr    = 1'b0;
        t.nd         = 0;
        t.disp       = '0;
        t.exp_pc     = '0;
        t.exp_err    = 1'b0;
        return t;
    endfunction

    task automatic run_case(input tcase_t tc);
        int start_cyc;
        bit done_seen;
        bit wrote;
        done_seen = 1'b0;
        wrote     = 1'b0;
        for (int i = 0; i < tc.nw; i++) begin
            prog_we    = 1'b1;
            prog_addr  = 6'(i);
            prog_wdata = tc.prog[i];
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
        exp_q.delete();
        for (int k = 0; k < tc.nd; k++) exp_q.push_back(tc.prog[tc.disp[k]]);
        exec_len  = tc.exec_len;
        disp_cnt  = 0;
        first_cyc = -1;
        start     = 1'b1;
        stop      = tc.sws;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        chk({tc.name, "_busy_after_start"}, busy, 1);
        chk({tc.name, "_error_cleared"}, error, 0);
        for (int t = 0; t < 3000; t++) begin
            if (seq_done) begin
                done_seen = 1'b1;
                break;
            end
            prog_we = 1'b0;
            start   = 1'b0;
            stop    = 1'b0;
            if (tc.busy_wr && !wrote && disp_cnt > 0) begin
                prog_we    = 1'b1;
                prog_addr  = 6'd1;
                prog_wdata = mk(4'h1, 16'd7, 33'h0_DEAD_0000, 26'h10, 8'd0, 16'd0);
                start      = 1'b1;
                wrote      = 1'b1;
            end
            if (tc.stop_after >= 0 && first_cyc >= 0 && (cyc - first_cyc) == tc.stop_after) stop = 1'b1;
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        chk({tc.name, "_seq_done_seen"}, done_seen, 1);
        chk({tc.name, "_exec_done_at_end"}, exec_done, 1);
        chk({tc.name, "_busy_at_end"}, busy, 0);
        chk({tc.name, "_pc_at_end"}, pc, tc.exp_pc);
        chk({tc.name, "_error_at_end"}, error, tc.exp_err);
        chk({tc.name, "_dispatch_count"}, disp_cnt, tc.nd);
        chk({tc.name, "_scoreboard_drained"}, exp_q.size(), 0);
        chk({tc.name, "_loop_flag_clear"}, dut.loop_act_q, 0);
        if (tc.nd > 0 && tc.disp[0] == 6'd0) begin
            // start-high cycle is cycle 1; dispatch lands in cycle 4.
            chk({tc.name, "_start_latency"}, first_cyc - start_cyc, 3);
        end
        @(posedge clk); #1;
        chk({tc.name, "_seq_done_one_cycle"}, seq_done, 0);
    endtask

    tcase_t tbl[8];

    initial begin
        logic [127:0] w_end;
        bit seen;
        w_end = mk(4'hF, 16'd0, 33'd0, 26'd0, 8'd0, 16'd0);

        tbl[0] = blank("play_end", 16);
        tbl[0].prog[0] = mk(4'h1, 16'd2, 33'h1_0000_0000, 26'h400, 8'd0, 16'd0);
        tbl[0].prog[1] = w_end;
        tbl[0].nw = 2; tbl[0].nd = 1; tbl[0].disp[0] = 6'd0; tbl[0].exp_pc = 6'd1;

        tbl[1] = blank("jump_loop", 4);
        tbl[1].prog[0] = mk(4'h1, 16'd3, 33'h0_0000_1000, 26'h40, 8'd0, 16'd0);
        tbl[1].prog[1] = mk(4'h1, 16'd5, 33'h0_0000_2000, 26'h80, 8'd0, 16'd0);
        tbl[1].prog[2] = mk(4'h2, 16'd0, 33'd0, 26'd0, 8'd0, 16'd2);
        tbl[1].prog[3] = w_end;
        tbl[1].nw = 4; tbl[1].nd = 6; tbl[1].exp_pc = 6'd3;
        for (int k = 0; k < 6; k++) tbl[1].disp[k] = 6'(k % 2);

        tbl[2] = blank("seg0_skip", 3);
        tbl[2].prog[0] = mk(4'h1, 16'd0, 33'h0_0000_3000, 26'h20, 8'd0, 16'd0);
        tbl[2].prog[1] = mk(4'h1, 16'd1, 33'h0_0000_4000, 26'h20, 8'd0, 16'd0);
        tbl[2].prog[2] = w_end;
        tbl[2].nw = 3; tbl[2].nd = 1; tbl[2].disp[0] = 6'd1; tbl[2].exp_pc = 6'd2;

        tbl[3] = blank("illegal_op", 2);
        tbl[3].prog[0] = mk(4'h1, 16'd1, 33'h0_0000_5000, 26'h20, 8'd0, 16'd0);
        tbl[3].prog[1] = mk(4'h7, 16'd1, 33'd0, 26'd0, 8'd0, 16'd0);
        tbl[3].prog[2] = w_end;
        tbl[3].nw = 3; tbl[3].nd = 1; tbl[3].disp[0] = 6'd0; tbl[3].exp_pc = 6'd1;
        tbl[3].exp_err = 1'b1;

        tbl[4] = blank("jump_c0", 5);
        tbl[4].prog[0] = mk(4'h1, 16'd4, 33'h0_0000_6000, 26'h20, 8'd0, 16'd0);
        tbl[4].prog[1] = mk(4'h2, 16'd0, 33'd0, 26'd0, 8'd0, 16'd0);
        tbl[4].prog[2] = w_end;
        tbl[4].nw = 3; tbl[4].nd = 1; tbl[4].disp[0] = 6'd0; tbl[4].exp_pc = 6'd2;

        tbl[5] = blank("instant_done", 0);
        tbl[5].prog[0] = mk(4'h1, 16'd1, 33'h0_0000_7000, 26'h20, 8'd0, 16'd0);
        tbl[5].prog[1] = mk(4'h1, 16'd2, 33'h0_0000_8000, 26'h20, 8'd0, 16'd0);
        tbl[5].prog[2] = w_end;
        tbl[5].nw = 3; tbl[5].nd = 2; tbl[5].disp[0] = 6'd0; tbl[5].disp[1] = 6'd1;
        tbl[5].exp_pc = 6'd2;

        tbl[6] = blank("stop_mid", 16);
        for (int k = 0; k < 3; k++)
            tbl[6].prog[k] = mk(4'h1, 16'(k + 1), 33'(32'h0001_0000 * (k + 1)), 26'h100, 8'd0, 16'd0);
        tbl[6].prog[3] = w_end;
        tbl[6].nw = 4; tbl[6].nd = 1; tbl[6].disp[0] = 6'd0; tbl[6].exp_pc = 6'd1;
        tbl[6].stop_after = 3;

        tbl[7] = tbl[0];
        tbl[7].name    = "start_stop_busy_wr";
        tbl[7].sws     = 1'b1;
        tbl[7].busy_wr = 1'b1;

        rst        = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        start      = 1'b0;
        stop       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_instr_out", instr_out, 0);
        chk("reset_instr_valid", instr_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pc", pc, 0);
        chk("reset_seq_done", seq_done, 0);
        chk("reset_error", error, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // stop while idle must not be remembered by the next run
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_case(tbl[i]);
            if (tbl[i].exp_err) begin
                @(posedge clk); #1;
                chk({tbl[i].name, "_error_sticky"}, error, 1);
            end
        end

        // reset in the middle of a dispatch drops instr_valid at once
        exp_q.delete();
        seen  = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (instr_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("midrst_dispatch_seen", seen, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_instr_valid", instr_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pc", pc, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // pc at the last address does not wrap: PLAY at DEPTH-1 then stop
        for (int i = 0; i < 64; i++) begin
            prog_we    = 1'b1;
            prog_addr  = 6'(i);
            prog_wdata = (i == 63) ? mk(4'h1, 16'd3, 33'h1_2345_6780, 26'h55, 8'd0, 16'd0)
                                   : mk(4'h1, 16'd0, 33'(i), 26'd1, 8'd0, 16'd0);
            @(posedge clk); #1;
        end
        prog_we  = 1'b0;
        exp_q.delete();
        exp_q.push_back(mk(4'h1, 16'd3, 33'h1_2345_6780, 26'h55, 8'd0, 16'd0));
        exec_len = 6;
        disp_cnt = 0;
        seen     = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            if (seq_done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("wrap_seq_done_seen", seen, 1);
        chk("wrap_dispatch_count", disp_cnt, 1);
        chk("wrap_pc", pc, 63);
        chk("wrap_busy", busy, 0);
        chk("wrap_error", error, 0);

        // executor never finishes
        prog_we    = 1'b1;
        prog_addr  = 6'd0;
        prog_wdata = mk(4'h1, 16'd1, 33'h0_0000_9000, 26'h10, 8'd0, 16'd0);
        @(posedge clk); #1;
        prog_addr  = 6'd1;
        prog_wdata = w_end;
        @(posedge clk); #1;
        prog_we   = 1'b0;
        exp_q.delete();
        exp_q.push_back(mk(4'h1, 16'd1, 33'h0_0000_9000, 26'h10, 8'd0, 16'd0));
        exec_hold = 1'b1;
        seen      = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            if (seq_done) seen = 1'b1;
            @(posedge clk); #1;
        end
`ifdef SEQ_WATCHDOG_EN
        chk("wdog_seq_done_seen", seen, 1);
        chk("wdog_error", error, 1);
        chk("wdog_busy", busy, 0);
`else
        chk("hang_busy", busy, 1);
        chk("hang_no_seq_done", seen, 0);
        chk("hang_no_error", error, 0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        exec_hold = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #1;
        chk("final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
